// File: rtl/ws2812_pkg.sv
// Shared types and timing helpers for the WS2812 chain driver.
package ws2812_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StBitHigh,
        StBitLow,
        StLatch
    } state_e;

    localparam int unsigned DefClkFre   = 27_000_000;
    localparam int unsigned DefT1hNs    = 850;
    localparam int unsigned DefT1lNs    = 400;
    localparam int unsigned DefT0hNs    = 400;
    localparam int unsigned DefT0lNs    = 850;
    localparam int unsigned DefTresetUs = 80;

    // Nanoseconds to clock cycles, truncated, never below one cycle.
    function automatic int unsigned cyc(input longint unsigned clk_fre,
                                        input longint unsigned ns);
        longint unsigned c;
        c = (clk_fre / 64'd1000) * ns / 64'd1_000_000;
        return (c < 64'd1) ? 32'd1 : 32'(c);
    endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Emits one WS2812 bit period: high then low, lengths chosen by the bit value.
module ws2812_bit_tx #(
    parameter int unsigned T1H = 22,
    parameter int unsigned T1L = 10,
    parameter int unsigned T0H = 10,
    parameter int unsigned T0L = 22
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_strobe,
    input  logic i_bit,
    output logic o_high_done,
    output logic o_bit_done
);

    localparam int unsigned CW = 16;

    logic          r_active;
    logic          r_low;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_th_last;
    logic [CW-1:0] w_tl_last;

    assign w_th_last   = i_bit ? CW'(T1H - 1) : CW'(T0H - 1);
    assign w_tl_last   = i_bit ? CW'(T1L - 1) : CW'(T0L - 1);
    assign o_high_done = r_active && !r_low && (r_cnt == w_th_last);
    assign o_bit_done  = r_active && r_low && (r_cnt == w_tl_last);

    // A strobe on the final low cycle chains straight into the next bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active <= 1'b0;
            r_low    <= 1'b0;
            r_cnt    <= '0;
        end else if (i_strobe) begin
            r_active <= 1'b1;
            r_low    <= 1'b0;
            r_cnt    <= '0;
        end else if (o_high_done) begin
            r_low <= 1'b1;
            r_cnt <= '0;
        end else if (o_bit_done) begin
            r_active <= 1'b0;
            r_low    <= 1'b0;
            r_cnt    <= '0;
        end else if (r_active) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ws2812_chain.sv
// WS2812 strip driver: host-writable frame buffer serialised MSB-first onto one data line.
module ws2812_chain
    import ws2812_pkg::*;
#(
    parameter int unsigned CLK_FRE      = DefClkFre,
    parameter int unsigned LED_COUNT    = 8,
    parameter int unsigned BIT_WIDTH    = 24,
    parameter int unsigned T1H_NS       = DefT1hNs,
    parameter int unsigned T1L_NS       = DefT1lNs,
    parameter int unsigned T0H_NS       = DefT0hNs,
    parameter int unsigned T0L_NS       = DefT0lNs,
    parameter int unsigned TRESET_US    = DefTresetUs,
    parameter int unsigned AUTO_REFRESH = 0,
    parameter int unsigned AW           = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr_en,
    input  logic [AW-1:0]        i_wr_addr,
    input  logic [BIT_WIDTH-1:0] i_wr_data,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_ws2812
);

    localparam int unsigned C1H  = cyc(64'(CLK_FRE), 64'(T1H_NS));
    localparam int unsigned C1L  = cyc(64'(CLK_FRE), 64'(T1L_NS));
    localparam int unsigned C0H  = cyc(64'(CLK_FRE), 64'(T0H_NS));
    localparam int unsigned C0L  = cyc(64'(CLK_FRE), 64'(T0L_NS));
    localparam int unsigned CRST = cyc(64'(CLK_FRE), 64'(TRESET_US) * 64'd1000);
    localparam int unsigned BW   = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam int unsigned LW   = $clog2(CRST + 1);

    // Not cleared by reset, so a reset mid-frame keeps the pixel data.
    logic [BIT_WIDTH-1:0] r_mem [LED_COUNT] = '{default: '0};

    state_e               r_state;
    state_e               w_state_next;
    logic [BIT_WIDTH-1:0] r_shift;
    logic [AW-1:0]        r_led;
    logic [BW-1:0]        r_bit;
    logic [LW-1:0]        r_lcnt;
    logic                 r_ws2812;
    logic                 r_done;
    logic [AW-1:0]        w_rd_addr;
    logic [BIT_WIDTH-1:0] w_rd_data;
    logic                 w_start;
    logic                 w_wr_ok;
    logic                 w_word_end;
    logic                 w_last_led;
    logic                 w_frame_end;
    logic                 w_latch_end;
    logic                 w_strobe;
    logic                 w_high_done;
    logic                 w_bit_done;

    assign w_start     = i_start || (AUTO_REFRESH != 0);
    assign w_wr_ok     = {1'b0, i_wr_addr} < (AW + 1)'(LED_COUNT);
    assign w_word_end  = r_bit == BW'(BIT_WIDTH - 1);
    assign w_last_led  = r_led == AW'(LED_COUNT - 1);
    assign w_frame_end = w_word_end && w_last_led;
    assign w_latch_end = (r_state == StLatch) && (r_lcnt == LW'(CRST - 1));
    assign w_strobe    = (r_state == StLoad) ||
                         ((r_state == StBitLow) && w_bit_done && !w_frame_end);
    assign w_rd_addr   = (r_state == StLoad) ? '0 : r_led + AW'(1);
    assign w_rd_data   = r_mem[w_rd_addr];

    assign o_busy   = r_state != StIdle;
    assign o_done   = r_done;
    assign o_ws2812 = r_ws2812;

    always_ff @(posedge i_clk) begin
        if (i_wr_en && w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    ws2812_bit_tx #(
        .T1H (C1H),
        .T1L (C1L),
        .T0H (C0H),
        .T0L (C0L)
    ) u_bit_tx (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_strobe    (w_strobe),
        .i_bit       (r_shift[BIT_WIDTH-1]),
        .o_high_done (w_high_done),
        .o_bit_done  (w_bit_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:    if (w_start) w_state_next = StLoad;
            StLoad:    w_state_next = StBitHigh;
            StBitHigh: if (w_high_done) w_state_next = StBitLow;
            StBitLow:  if (w_bit_done) w_state_next = w_frame_end ? StLatch : StBitHigh;
            StLatch:   if (w_latch_end) w_state_next = w_start ? StLoad : StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift  <= '0;
            r_led    <= '0;
            r_bit    <= '0;
            r_lcnt   <= '0;
            r_ws2812 <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ws2812 <= r_state == StBitHigh;
            r_done   <= w_latch_end;
            case (r_state)
                StLoad: begin
                    r_shift <= w_rd_data;
                    r_led   <= '0;
                    r_bit   <= '0;
                end
                StBitLow: begin
                    if (w_bit_done) begin
                        if (w_word_end) begin
                            r_bit <= '0;
                            if (!w_last_led) begin
                                r_led   <= r_led + AW'(1);
                                r_shift <= w_rd_data;
                            end
                        end else begin
                            r_bit   <= r_bit + BW'(1);
                            r_shift <= {r_shift[BIT_WIDTH-2:0], 1'b0};
                        end
                    end
                end
                StLatch: r_lcnt <= w_latch_end ? '0 : r_lcnt + LW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_chain.sv
// Directed bench: DUT A (4 LEDs, 27 MHz, one-shot) and DUT B (3x32-bit, 50 MHz, auto-refresh).
module tb_ws2812_chain;

    localparam int LA = 1 + 96 * 32 + 2160;
    localparam int LB = 1 + 96 * 62 + 4000;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, wr_en_a = 1'b0, start_a = 1'b0;
    logic [1:0]  wr_addr_a = '0;
    logic [23:0] wr_data_a = '0;
    logic        busy_a, done_a, ws_a;
    logic        rst_b = 1'b1, wr_en_b = 1'b0, start_b = 1'b0;
    logic [1:0]  wr_addr_b = '0;
    logic [31:0] wr_data_b = '0;
    logic        busy_b, done_b, ws_b;
    logic        sel_b = 1'b0;
    logic        mon_ws, mon_busy, mon_done;

    int checks = 0;
    int errors = 0;
    logic line_q[$];
    logic busy_q[$];
    logic done_q[$];

    always #5 clk = ~clk;

    assign mon_ws   = sel_b ? ws_b : ws_a;
    assign mon_busy = sel_b ? busy_b : busy_a;
    assign mon_done = sel_b ? done_b : done_a;

    ws2812_chain #(.LED_COUNT(4)) u_dut_a (
        .i_clk     (clk),
        .i_reset   (rst_a),
        .i_wr_en   (wr_en_a),
        .i_wr_addr (wr_addr_a),
        .i_wr_data (wr_data_a),
        .i_start   (start_a),
        .o_busy    (busy_a),
        .o_done    (done_a),
        .o_ws2812  (ws_a)
    );

    ws2812_chain #(
        .CLK_FRE      (50_000_000),
        .LED_COUNT    (3),
        .BIT_WIDTH    (32),
        .AUTO_REFRESH (1)
    ) u_dut_b (
        .i_clk     (clk),
        .i_reset   (rst_b),
        .i_wr_en   (wr_en_b),
        .i_wr_addr (wr_addr_b),
        .i_wr_data (wr_data_b),
        .i_start   (start_b),
        .o_busy    (busy_b),
        .o_done    (done_b),
        .o_ws2812  (ws_b)
    );

    task automatic capture(input int n);
        line_q.delete();
        busy_q.delete();
        done_q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            line_q.push_back(mon_ws);
            busy_q.push_back(mon_busy);
            done_q.push_back(mon_done);
        end
    endtask

    task automatic decode(input int p0, input int nbits, input int t1h, input int t0h,
                          input int t1l, input int t0l,
                          output logic [127:0] bits, output int bad);
        int p, h, l;
        logic b;
        bits = '0;
        bad  = 0;
        p    = p0;
        for (int j = 0; j < nbits; j++) begin
            h = 0;
            l = 0;
            while (p < line_q.size() && line_q[p] === 1'b1) begin h++; p++; end
            while (p < line_q.size() && line_q[p] !== 1'b1) begin l++; p++; end
            b    = h > (t1h + t0h) / 2;
            bits = {bits[126:0], b};
            if (h != (b ? t1h : t0h) || (j != nbits - 1 && l != (b ? t1l : t0l))) bad++;
        end
    endtask

    function automatic int first_done(input int from);
        for (int i = from; i < done_q.size(); i++) if (done_q[i] === 1'b1) return i;
        return -1;
    endfunction

    task automatic write_a(input logic [1:0] a, input logic [23:0] d);
        wr_en_a = 1'b1; wr_addr_a = a; wr_data_a = d;
        @(negedge clk);
        wr_en_a = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ws_a !== 1'b0) begin errors++; $display("FAIL reset_ws got %b want 0", ws_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_a); end
        rst_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame();
        logic [127:0] bits, exp;
        int bad;
        write_a(2'd0, 24'hFF0000);
        write_a(2'd1, 24'h000001);
        write_a(2'd2, 24'hA5A5A5);
        write_a(2'd3, 24'hC33C81);
        exp = {32'h0, 24'hFF0000, 24'h000001, 24'hA5A5A5, 24'hC33C81};
        start_a = 1'b1;
        fork
            capture(LA + 5);
            begin @(negedge clk); start_a = 1'b0; end
        join
        checks++; if (busy_q[0] !== 1'b1) begin errors++; $display("FAIL frame_busy_rise got %b want 1", busy_q[0]); end
        checks++; if ({line_q[1], line_q[2]} !== 2'b01) begin errors++; $display("FAIL frame_line_rise got %b want 01", {line_q[1], line_q[2]}); end
        decode(2, 96, 22, 10, 10, 22, bits, bad);
        checks++; if (bits !== exp) begin errors++; $display("FAIL frame_data got %h want %h", bits, exp); end
        checks++; if (bad != 0) begin errors++; $display("FAIL frame_timing got %0d bad bits want 0", bad); end
        checks++; if (first_done(0) != LA) begin errors++; $display("FAIL frame_done_pos got %0d want %0d", first_done(0), LA); end
        checks++; if (done_q[LA + 1] !== 1'b0) begin errors++; $display("FAIL frame_done_width got %b want 0", done_q[LA + 1]); end
        checks++; if ({busy_q[LA - 1], busy_q[LA]} !== 2'b10) begin errors++; $display("FAIL frame_busy_fall got %b want 10", {busy_q[LA - 1], busy_q[LA]}); end
    endtask

    task automatic test_start_held();
        logic [127:0] bits, exp;
        int bad, lows;
        exp = {32'h0, 24'hFF0000, 24'h000001, 24'hA5A5A5, 24'hC33C81};
        start_a = 1'b1;
        fork
            capture(2 * LA + 5);
            begin repeat (2 * LA - 10) @(negedge clk); start_a = 1'b0; end
        join
        lows = 0;
        for (int i = 0; i < 2 * LA; i++) if (busy_q[i] !== 1'b1) lows++;
        checks++; if (first_done(0) != LA) begin errors++; $display("FAIL held_done1 got %0d want %0d", first_done(0), LA); end
        checks++; if (first_done(LA + 1) != 2 * LA) begin errors++; $display("FAIL held_done2 got %0d want %0d", first_done(LA + 1), 2 * LA); end
        checks++; if (lows != 0) begin errors++; $display("FAIL held_busy_gap got %0d low cycles want 0", lows); end
        checks++; if (busy_q[2 * LA] !== 1'b0) begin errors++; $display("FAIL held_idle got %b want 0", busy_q[2 * LA]); end
        decode(LA + 2, 96, 22, 10, 10, 22, bits, bad);
        checks++; if (bits !== exp || bad != 0) begin errors++; $display("FAIL held_frame2 got %h bad %0d want %h bad 0", bits, bad, exp); end
    endtask

    task automatic test_midframe_write();
        logic [127:0] bits, exp;
        int bad;
        start_a = 1'b1;
        fork
            capture(LA + 5);
            begin
                @(negedge clk); start_a = 1'b0;
                repeat (999) @(negedge clk);
                wr_en_a = 1'b1; wr_addr_a = 2'd0; wr_data_a = 24'h0F0F0F; start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0; wr_addr_a = 2'd3; wr_data_a = 24'h8100FF;
                @(negedge clk);
                wr_en_a = 1'b0;
            end
        join
        exp = {32'h0, 24'hFF0000, 24'h000001, 24'hA5A5A5, 24'h8100FF};
        decode(2, 96, 22, 10, 10, 22, bits, bad);
        checks++; if (bits !== exp || bad != 0) begin errors++; $display("FAIL mid_current got %h bad %0d want %h bad 0", bits, bad, exp); end
        checks++; if (busy_q[LA + 4] !== 1'b0) begin errors++; $display("FAIL mid_start_ignored got %b want 0", busy_q[LA + 4]); end
        start_a = 1'b1;
        fork
            capture(LA + 5);
            begin @(negedge clk); start_a = 1'b0; end
        join
        exp = {32'h0, 24'h0F0F0F, 24'h000001, 24'hA5A5A5, 24'h8100FF};
        decode(2, 96, 22, 10, 10, 22, bits, bad);
        checks++; if (bits !== exp || bad != 0) begin errors++; $display("FAIL mid_next got %h bad %0d want %h bad 0", bits, bad, exp); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] bits, exp;
        int bad;
        start_a = 1'b1;
        fork
            capture(2400);
            begin
                @(negedge clk); start_a = 1'b0;
                repeat (2310) @(negedge clk);
                rst_a = 1'b1;
                @(negedge clk);
                rst_a = 1'b0;
            end
        join
        checks++; if (line_q[2310] !== 1'b1) begin errors++; $display("FAIL rst_pre_high got %b want 1", line_q[2310]); end
        checks++; if (line_q[2311] !== 1'b0) begin errors++; $display("FAIL rst_line_low got %b want 0", line_q[2311]); end
        checks++; if (busy_q[2311] !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_q[2311]); end
        checks++; if (busy_q[2399] !== 1'b0) begin errors++; $display("FAIL rst_stays_idle got %b want 0", busy_q[2399]); end
        start_a = 1'b1;
        fork
            capture(LA + 5);
            begin @(negedge clk); start_a = 1'b0; end
        join
        exp = {32'h0, 24'h0F0F0F, 24'h000001, 24'hA5A5A5, 24'h8100FF};
        decode(2, 96, 22, 10, 10, 22, bits, bad);
        checks++; if (bits !== exp || bad != 0) begin errors++; $display("FAIL rst_buffer got %h bad %0d want %h bad 0", bits, bad, exp); end
    endtask

    task automatic test_auto_refresh();
        logic [127:0] bits, exp;
        int bad, lows;
        sel_b = 1'b1;
        exp = {32'h0, 32'h800000FF, 32'h01234567, 32'hFFFF0000};
        @(negedge clk);
        rst_b = 1'b0; wr_en_b = 1'b1; wr_addr_b = 2'd0; wr_data_b = 32'h800000FF;
        fork
            capture(2 * LB + 5);
            begin
                @(negedge clk); wr_addr_b = 2'd1; wr_data_b = 32'h01234567;
                @(negedge clk); wr_addr_b = 2'd2; wr_data_b = 32'hFFFF0000;
                @(negedge clk); wr_addr_b = 2'd3; wr_data_b = 32'hDEADBEEF;
                @(negedge clk); wr_en_b = 1'b0;
            end
        join
        lows = 0;
        for (int i = 0; i < 2 * LB + 5; i++) if (busy_q[i] !== 1'b1) lows++;
        checks++; if ({line_q[1], line_q[2]} !== 2'b01) begin errors++; $display("FAIL auto_line_rise got %b want 01", {line_q[1], line_q[2]}); end
        decode(2, 96, 42, 20, 20, 42, bits, bad);
        checks++; if (bits !== exp) begin errors++; $display("FAIL auto_data1 got %h want %h", bits, exp); end
        checks++; if (bad != 0) begin errors++; $display("FAIL auto_timing got %0d bad bits want 0", bad); end
        checks++; if (first_done(0) != LB) begin errors++; $display("FAIL auto_done1 got %0d want %0d", first_done(0), LB); end
        checks++; if (first_done(LB + 1) != 2 * LB) begin errors++; $display("FAIL auto_done2 got %0d want %0d", first_done(LB + 1), 2 * LB); end
        checks++; if ({line_q[LB + 1], line_q[LB + 2]} !== 2'b01) begin errors++; $display("FAIL auto_restart got %b want 01", {line_q[LB + 1], line_q[LB + 2]}); end
        checks++; if (lows != 0) begin errors++; $display("FAIL auto_busy_gap got %0d low cycles want 0", lows); end
        decode(LB + 2, 96, 42, 20, 20, 42, bits, bad);
        checks++; if (bits !== exp || bad != 0) begin errors++; $display("FAIL auto_data2 got %h bad %0d want %h bad 0", bits, bad, exp); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_start_held();
        test_midframe_write();
        test_reset_mid();
        test_auto_refresh();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
